tthbif_cfg_ctrl: RTL
====================

TTHBIF_CFG_CTRL -- requirements
Module: tthbif_cfg_ctrl

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 1_000_000, inter-byte timeout in clk_i cycles.
REQ-002 Parameters SHALL also include: ID_VALUE, default 8'hA5, read-only identification byte.
REQ-003 Ports SHALL be exactly the following.
- clk_i  input  1  sole clock.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  block enable.
- rx_data_valid_i  input  1  single-cycle strobe for one received UART byte.
- rx_data_i  input  8  received byte.
- tx_data_ready_i  input  1  UART transmitter can accept a byte.
- tx_data_valid_o  output  1  response byte valid.
- tx_data_o  output  8  response byte.
- rx_flop_tap_sel_o  output  2  tthbif RX flop-tap select.
- rx_comb_tap_sel_o  output  2  tthbif RX comb-tap select.
- tx_flop_tap_sel_o  output  2  tthbif TX flop-tap select.
- tx_comb_tap_sel_o  output  2  tthbif TX comb-tap select.

Function
REQ-004 Command byte format SHALL be: bit7 = 1 for write, 0 for read; bits[6:3] must be 0; bits[2:0] = address.
REQ-005 Register map SHALL be:
- 0 rx_flop_tap_sel, RW, bits[1:0].
- 1 rx_comb_tap_sel, RW, bits[1:0].
- 2 tx_flop_tap_sel, RW, bits[1:0].
- 3 tx_comb_tap_sel, RW, bits[1:0].
- 4 ID, RO, returns ID_VALUE.
- 5 SCRATCH, RW, 8 bits.
- 6-7 reserved: reads return 8'h00; writes are ignored but still ACKed.
REQ-006 Reads of 2-bit registers SHALL return the value zero-extended; writes SHALL use data bits[1:0] and ignore bits[7:2].
REQ-007 FSM states SHALL be IDLE, WDATA and RESP.
REQ-008 IDLE SHALL handle a received byte as follows:
- Bits[6:3] nonzero: load 8'h3F (NAK) and go to RESP.
- Read: load the register value and go to RESP.
- Write: latch the address and go to WDATA.
REQ-009 In WDATA, a received byte SHALL update the addressed register on the cycle after the strobe, load 8'h4B (ACK) and go to RESP.
REQ-010 In RESP, tx_data_valid_o SHALL be 1 with tx_data_o stable until a cycle where tx_data_ready_i is 1; the FSM SHALL then return to IDLE.
REQ-011 tx_data_valid_o SHALL rise on the cycle after the strobe that completes the command (1-cycle latency).
REQ-012 Received bytes arriving while in RESP SHALL be dropped with no state change.
REQ-013 In WDATA, a counter SHALL count cycles without a byte. On reaching TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE with no register update and no response.
REQ-014 The timeout counter SHALL clear on entry to WDATA and SHALL saturate, never wrap.
REQ-015 While en_i is 0:
- The FSM SHALL be forced to IDLE.
- tx_data_valid_o SHALL be 0.
- rx strobes SHALL be ignored.
- Register contents SHALL be retained.
REQ-016 Tap-select outputs SHALL come directly from flops and SHALL change only on a write completion.

Reset
REQ-017 Asserting rst_ni low SHALL asynchronously set the following, at any point including mid-command:
- FSM to IDLE and timeout counter to 0.
- tx_data_valid_o=0 and tx_data_o=8'h00.
- All four tap selects to 2'b11.
- SCRATCH to 8'h00.
REQ-018 Deassertion SHALL be synchronous to clk_i by external synchronizer; the block adds none.

Structure
REQ-019 tthbif_pkg SHALL hold:
- The register address localparams.
- CMD_WR_BIT.
- ACK=8'h4B and NAK=8'h3F.
- The FSM state enum.
- The tap-select width (2).
REQ-020 The block SHALL be a single module with no sub-modules; it replaces the hardwired tap-select constants at the top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- After reset: all tap selects 2'b11, tx_data_valid_o=0.
- Bytes 8'h82, 8'h01: ACK 8'h4B, then tx_flop_tap_sel_o=2'b01.
- Byte 8'h04: responds 8'hA5. Bytes 8'h85, 8'h5A, 8'h05: ACK, then 8'h5A.
- Byte 8'h48: NAK 8'h3F with no register change. With tx_data_ready_i held 0 for 10 cycles, tx_data_valid_o and tx_data_o stay stable, and an extra rx byte in that window is dropped.
- Byte 8'h80 then no byte for TIMEOUT_CYCLES (bench sets it to 16): FSM returns to IDLE with no response and rx_flop_tap_sel_o still 2'b11; next byte 8'h00 reads 8'h03.
- rst_ni pulsed low while in WDATA after a write to 8'h81: tap selects return to 2'b11, and the following byte is parsed as a command.

Source files
------------

// File: rtl/tthbif_pkg.sv
// tthbif_pkg: shared constants and types for the tthbif configuration controller.
package tthbif_pkg;
    localparam int TAP_W      = 2;
    localparam int CMD_WR_BIT = 7;
    localparam logic [2:0] ADDR_RX_FLOP = 3'd0;
    localparam logic [2:0] ADDR_RX_COMB = 3'd1;
    localparam logic [2:0] ADDR_TX_FLOP = 3'd2;
    localparam logic [2:0] ADDR_TX_COMB = 3'd3;
    localparam logic [2:0] ADDR_ID      = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH = 3'd5;
    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h3F;
    typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;
endpackage

// File: rtl/tthbif_cfg_ctrl.sv
// tthbif_cfg_ctrl: UART byte-command register block driving the tthbif tap selects.
module tthbif_cfg_ctrl
    import tthbif_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] ID_VALUE       = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             rx_data_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             tx_data_ready_i,
    output logic             tx_data_valid_o,
    output logic [7:0]       tx_data_o,
    output logic [TAP_W-1:0] rx_flop_tap_sel_o,
    output logic [TAP_W-1:0] rx_comb_tap_sel_o,
    output logic [TAP_W-1:0] tx_flop_tap_sel_o,
    output logic [TAP_W-1:0] tx_comb_tap_sel_o
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    state_t         state, state_nxt;
    logic [2:0]     addr;
    logic [CW-1:0]  cnt;
    logic [7:0]     scratch, rd_data;
    logic           rx, bad, is_wr, timeout;
    assign rx      = en_i && rx_data_valid_i;
    assign bad     = |rx_data_i[6:3];
    assign is_wr   = rx_data_i[CMD_WR_BIT];
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        rd_data = 8'h00;
        case (rx_data_i[2:0])
            ADDR_RX_FLOP: rd_data = {{(8-TAP_W){1'b0}}, rx_flop_tap_sel_o};
            ADDR_RX_COMB: rd_data = {{(8-TAP_W){1'b0}}, rx_comb_tap_sel_o};
            ADDR_TX_FLOP: rd_data = {{(8-TAP_W){1'b0}}, tx_flop_tap_sel_o};
            ADDR_TX_COMB: rd_data = {{(8-TAP_W){1'b0}}, tx_comb_tap_sel_o};
            ADDR_ID:      rd_data = ID_VALUE;
            ADDR_SCRATCH: rd_data = scratch;
            default:      rd_data = 8'h00;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (!en_i) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (rx) state_nxt = (bad || !is_wr) ? RESP : WDATA;
                WDATA:   state_nxt = rx ? RESP : (timeout ? IDLE : WDATA);
                RESP:    if (tx_data_ready_i) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end
    assign tx_data_valid_o = en_i && state == RESP;
    // Datapath: address latch, response byte, timeout counter and register file
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr              <= '0;
            cnt               <= '0;
            tx_data_o         <= 8'h00;
            scratch           <= 8'h00;
            rx_flop_tap_sel_o <= '1;
            rx_comb_tap_sel_o <= '1;
            tx_flop_tap_sel_o <= '1;
            tx_comb_tap_sel_o <= '1;
        end else begin
            cnt <= (state == WDATA && !rx) ? (&cnt ? cnt : cnt + 1'b1) : '0;
            if (state == IDLE && rx) begin
                if (bad)        tx_data_o <= NAK;
                else if (is_wr) addr      <= rx_data_i[2:0];
                else            tx_data_o <= rd_data;
            end
            if (state == WDATA && rx) begin
                tx_data_o <= ACK;
                case (addr)
                    ADDR_RX_FLOP: rx_flop_tap_sel_o <= rx_data_i[TAP_W-1:0];
                    ADDR_RX_COMB: rx_comb_tap_sel_o <= rx_data_i[TAP_W-1:0];
                    ADDR_TX_FLOP: tx_flop_tap_sel_o <= rx_data_i[TAP_W-1:0];
                    ADDR_TX_COMB: tx_comb_tap_sel_o <= rx_data_i[TAP_W-1:0];
                    ADDR_SCRATCH: scratch           <= rx_data_i;
                    default: ;
                endcase
            end
        end
    end
endmodule
